// File: rtl/instruction_fetch_stage.sv
// Fetch stage with IF/ID register: one outstanding imem request,
// a one-entry hold buffer for stalls, and branch redirect/drain.
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instruction,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        ifv_q, ifv_d;
   logic [31:0] ifpc_q, ifpc_d;
   logic [31:0] ifins_q, ifins_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] hpc_q, hpc_d;
   logic [31:0] hdata_q, hdata_d;

   logic        accept_ok;
   logic        req_fire;
   logic        load;
   logic [31:0] load_pc;
   logic [31:0] load_ins;

   assign accept_ok = !ifv_q || !stall;
   assign req_fire  = imem_req_valid && imem_req_ready;

   // State and datapath registers, synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         ifv_q   <= 1'b0;
         ifpc_q  <= 32'h0;
         ifins_q <= NOP_INSTR;
         cnt_q   <= 32'h0;
         hpc_q   <= 32'h0;
         hdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ifv_q   <= ifv_d;
         ifpc_q  <= ifpc_d;
         ifins_q <= ifins_d;
         cnt_q   <= cnt_d;
         hpc_q   <= hpc_d;
         hdata_q <= hdata_d;
      end
   end

   // Next-state: redirect drains any in-flight response not arriving now
   always_comb begin
      state_d = state_q;
      if (branch_taken) begin
         if (req_fire ||
             ((state_q == S_WAIT || state_q == S_DRAIN) &&
              !imem_rsp_valid))
            state_d = S_DRAIN;
         else
            state_d = S_REQ;
      end else begin
         unique case (state_q)
            S_REQ:   if (req_fire) state_d = S_WAIT;
            S_WAIT:  if (imem_rsp_valid)
                        state_d = accept_ok ? S_REQ : S_HOLD;
            S_HOLD:  if (accept_ok) state_d = S_REQ;
            S_DRAIN: if (imem_rsp_valid) state_d = S_REQ;
            default: state_d = S_REQ;
         endcase
      end
   end

   // Datapath: PC advance, IF/ID load/drain, hold buffer capture
   always_comb begin
      pc_d     = pc_q;
      ifv_d    = ifv_q;
      ifpc_d   = ifpc_q;
      ifins_d  = ifins_q;
      cnt_d    = cnt_q;
      hpc_d    = hpc_q;
      hdata_d  = hdata_q;
      load     = 1'b0;
      load_pc  = pc_q;
      load_ins = imem_rsp_data;
      if (branch_taken) begin
         pc_d    = {branch_target[31:2], 2'b00};
         ifv_d   = 1'b0;
         ifins_d = NOP_INSTR;
         hpc_d   = 32'h0;
         hdata_d = 32'h0;
      end else begin
         if (state_q == S_WAIT && imem_rsp_valid) begin
            pc_d = pc_q + 32'd4;
            if (accept_ok) begin
               load = 1'b1;
            end else begin
               hpc_d   = pc_q;
               hdata_d = imem_rsp_data;
            end
         end else if (state_q == S_HOLD && accept_ok) begin
            load     = 1'b1;
            load_pc  = hpc_q;
            load_ins = hdata_q;
         end
         if (load) begin
            ifv_d   = 1'b1;
            ifpc_d  = load_pc;
            ifins_d = load_ins;
            cnt_d   = cnt_q + 32'd1;
         end else if (ifv_q && !stall) begin
            ifv_d = 1'b0;
         end
      end
   end

   // Outputs: request only from S_REQ and never in a reset cycle
   always_comb begin
      imem_req_valid    = (state_q == S_REQ) && !reset;
      imem_addr         = pc_q;
      if_id_valid       = ifv_q;
      if_id_pc          = ifpc_q;
      if_id_instruction = ifins_q;
      fetch_count       = cnt_q;
   end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector table, hand
// sequences for wrap/reset, and random stimulus vs a queue model.
module tb_instruction_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] W1  = 32'h0050_0093;
   localparam logic [31:0] W2  = 32'h00A0_0113;
   localparam logic [31:0] W3  = 32'h00F0_0193;
   localparam logic [31:0] W4  = 32'h0140_0213;
   localparam logic [31:0] WS  = 32'hFE00_0EE3;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instruction;
   logic [31:0] fetch_count;

   int n_cmp = 0;
   int n_bad = 0;

   instruction_fetch_stage dut (
      .clock             (clock),
      .reset             (reset),
      .imem_req_valid    (imem_req_valid),
      .imem_req_ready    (imem_req_ready),
      .imem_addr         (imem_addr),
      .imem_rsp_valid    (imem_rsp_valid),
      .imem_rsp_data     (imem_rsp_data),
      .stall             (stall),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .if_id_valid       (if_id_valid),
      .if_id_pc          (if_id_pc),
      .if_id_instruction (if_id_instruction),
      .fetch_count       (fetch_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        st;
      logic        br;
      logic [31:0] tg;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_ifv;
      logic [31:0] e_ifpc;
      logic [31:0] e_ins;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl [22];

   // reference model: outstanding flag, stale flag, hold queue
   logic        m_out, m_stale;
   logic [63:0] m_hq[$];
   logic [31:0] m_pc, m_ifpc, m_ins, m_cnt;
   logic        m_ifv;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic drv(logic rst, logic rdy, logic rv, logic [31:0] rd,
                      logic st, logic br, logic [31:0] tg);
      reset          = rst;
      imem_req_ready = rdy;
      imem_rsp_valid = rv;
      imem_rsp_data  = rd;
      stall          = st;
      branch_taken   = br;
      branch_target  = tg;
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic chk_all(string tag, logic req, logic [31:0] addr,
                          logic ifv, logic [31:0] ifpc,
                          logic [31:0] ins, logic [31:0] cnt);
      #1;
      chk({tag, ".req"},  {31'b0, imem_req_valid}, {31'b0, req});
      chk({tag, ".addr"}, imem_addr, addr);
      chk({tag, ".ifv"},  {31'b0, if_id_valid}, {31'b0, ifv});
      chk({tag, ".ifpc"}, if_id_pc, ifpc);
      chk({tag, ".ins"},  if_id_instruction, ins);
      chk({tag, ".cnt"},  fetch_count, cnt);
   endtask

   function automatic logic m_reqv();
      return !m_out && (m_hq.size() == 0);
   endfunction

   task automatic m_load(logic [31:0] p, logic [31:0] d);
      m_ifv  = 1'b1;
      m_ifpc = p;
      m_ins  = d;
      m_cnt  = m_cnt + 32'd1;
   endtask

   task automatic m_step(logic rst, logic rdy, logic rv, logic [31:0] rd,
                         logic st, logic br, logic [31:0] tg);
      logic ok, loaded, fire;
      logic [63:0] e;
      fire = m_reqv() && rdy;
      if (rst) begin
         m_out = 0; m_stale = 0; m_hq.delete();
         m_pc = 0; m_ifv = 0; m_ifpc = 0; m_ins = NOP; m_cnt = 0;
      end else if (br) begin
         m_out   = (m_out && !rv) || fire;
         m_stale = m_out;
         m_hq.delete();
         m_pc  = tg & ~32'd3;
         m_ifv = 0;
         m_ins = NOP;
      end else begin
         ok = !m_ifv || !st;
         loaded = 0;
         if (m_out && rv) begin
            m_out = 0;
            if (m_stale) m_stale = 0;
            else begin
               if (ok) begin m_load(m_pc, rd); loaded = 1; end
               else m_hq.push_back({m_pc, rd});
               m_pc = m_pc + 32'd4;
            end
         end else if (m_hq.size() != 0 && ok) begin
            e = m_hq.pop_front();
            m_load(e[63:32], e[31:0]);
            loaded = 1;
         end else if (fire) begin
            m_out = 1;
         end
         if (!loaded && m_ifv && !st) m_ifv = 0;
      end
   endtask

   initial begin
      tbl[0]  = '{1,0,0,0,0,0,           1,0,0,0,NOP,0};
      tbl[1]  = '{0,1,W1,0,0,0,          0,0,0,0,NOP,0};
      tbl[2]  = '{1,0,0,0,0,0,           1,4,1,0,W1,1};
      tbl[3]  = '{0,1,W2,0,0,0,          0,4,0,0,W1,1};
      tbl[4]  = '{1,0,0,0,0,0,           1,8,1,4,W2,2};
      tbl[5]  = '{0,1,W3,0,0,0,          0,8,0,4,W2,2};
      tbl[6]  = '{0,0,0,0,0,0,           1,12,1,8,W3,3};
      tbl[7]  = '{0,0,0,0,0,0,           1,12,0,8,W3,3};
      tbl[8]  = '{1,0,0,0,0,0,           1,12,0,8,W3,3};
      tbl[9]  = '{0,1,W4,0,0,0,          0,12,0,8,W3,3};
      tbl[10] = '{1,0,0,1,0,0,           1,16,1,12,W4,4};
      tbl[11] = '{0,1,WS,1,0,0,          0,16,1,12,W4,4};
      tbl[12] = '{1,0,0,1,0,0,           0,20,1,12,W4,4};
      tbl[13] = '{1,0,0,0,0,0,           0,20,1,12,W4,4};
      tbl[14] = '{0,0,0,0,0,0,           1,20,1,16,WS,5};
      tbl[15] = '{1,0,0,0,0,0,           1,20,0,16,WS,5};
      tbl[16] = '{0,0,0,0,1,32'h102,     0,20,0,16,WS,5};
      tbl[17] = '{1,0,0,0,0,0,           0,32'h100,0,16,NOP,5};
      tbl[18] = '{1,1,32'hDEADBEEF,0,0,0,0,32'h100,0,16,NOP,5};
      tbl[19] = '{1,0,0,0,0,0,           1,32'h100,0,16,NOP,5};
      tbl[20] = '{0,1,32'h11111111,0,1,32'h200,
                  0,32'h100,0,16,NOP,5};
      tbl[21] = '{0,0,0,0,0,0,           1,32'h200,0,16,NOP,5};

      drv(1, 0, 0, 0, 0, 0, 0);
      step();
      step();
      chk_all("reset", 0, 0, 0, 0, NOP, 0);

      for (int i = 0; i < 22; i++) begin
         drv(0, tbl[i].rdy, tbl[i].rv, tbl[i].rd,
             tbl[i].st, tbl[i].br, tbl[i].tg);
         chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                 tbl[i].e_ifv, tbl[i].e_ifpc, tbl[i].e_ins, tbl[i].e_cnt);
         step();
      end

      // pc wrap at top of address space
      drv(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
      step();
      drv(0, 1, 0, 0, 0, 0, 0);
      chk_all("wrap.req", 1, 32'hFFFF_FFFC, 0, 16, NOP, 5);
      step();
      drv(0, 0, 1, W1, 0, 0, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      chk_all("wrap.load", 1, 0, 1, 32'hFFFF_FFFC, W1, 6);

      // reset while a request is outstanding
      drv(0, 1, 0, 0, 0, 0, 0);
      step();
      drv(1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rstmid.req", {31'b0, imem_req_valid}, 32'd0);
      step();
      drv(0, 0, 1, 32'h2222_2222, 0, 0, 0);
      chk_all("rstmid.a", 1, 0, 0, 0, NOP, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      chk_all("rstmid.b", 1, 0, 0, 0, NOP, 0);

      // random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         logic        rst, rdy, rv, st, br;
         logic [31:0] rd, tg;
         rst = (i == 0) || ($urandom_range(0, 99) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         rv  = ($urandom_range(0, 2) != 0);
         rd  = $urandom;
         st  = ($urandom_range(0, 2) == 0);
         br  = ($urandom_range(0, 9) == 0);
         tg  = $urandom;
         if ($urandom_range(0, 19) == 0) tg = 32'hFFFF_FFFC;
         drv(rst, rdy, rv, rd, st, br, tg);
         if (i != 0)
            chk_all($sformatf("rnd%0d", i), !rst && m_reqv(), m_pc,
                    m_ifv, m_ifpc, m_ins, m_cnt);
         m_step(rst, rdy, rv, rd, st, br, tg);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
